// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned IMEM_DEPTH = 2 ** ADDR_W;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0007_8000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry queue of fetched {instruction, pc} pairs feeding decode.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slot_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  assign count  = count_q;
  assign head   = slot_q[rd_ptr_q];

  // Pointer and occupancy tracking; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      slot_q[wr_ptr_q] <= wr_entry;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count_q == 2'd2));

endmodule

// File: rtl/fetch_sequencer.sv
// PC / fetch controller: issues instruction-memory reads, tracks the
// one-cycle read latency and hands fetched words to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned INST_W    = fetch_pkg::INST_W,
  parameter int unsigned ADDR_W    = fetch_pkg::ADDR_W,
  parameter int unsigned START_PC  = 0,
  parameter int unsigned PROG_LAST = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(PROG_LAST);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;

  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;
  logic              deq;
  logic              redir;
  logic              issue;
  logic              push;
  logic [2:0]        pending;
  logic [2:0]        room;

  assign inst_valid = (count != 2'd0);
  assign deq        = inst_valid && inst_ready;
  assign redir      = redirect_valid && (state_q == RUN || state_q == DRAIN);

  // occupancy + inflight - deq < 2, rearranged to avoid underflow
  assign pending = {1'b0, count} + {2'b0, inflight_q};
  assign room    = 3'd2 + {2'b0, deq};
  assign issue   = (state_q == RUN) && !redir && (pending < room);

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push          = inflight_q && !redir;
  assign wr_entry.inst = imem_rdata;
  assign wr_entry.pc   = inflight_pc_q;

  assign imem_en   = issue;
  assign imem_addr = issue ? pc_q : '0;
  assign inst_out  = inst_valid ? head.inst : NOP_INST;
  assign pc_out    = inst_valid ? head.pc : '0;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  fetch_skid_fifo u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (deq),
    .flush    (redir),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  // Next-state and next-PC selection; redirect overrides halt detection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_A;
        end
      end
      RUN: begin
        if (issue) begin
          pc_d = pc_q + 1'b1;
          if (pc_q == LAST_A) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count == 2'd0 && !inflight_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redir) begin
      state_d = RUN;
      pc_d    = redirect_pc;
    end
  end

  // State, PC and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= START_A;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
    end
  end

endmodule
